hex_display_ctrl: RTL and testbench

Parametrised successor to the fixed six-digit HEX PIO path. It drives N_DIGITS active-low seven-segment digits from an HPS-visible register set. It adds four modes: static, blink, scroll, and free-running hex count. It sits between the HPS lightweight bridge (Avalon-MM slave) and the HEX pins inside fpga_portion.

---
 rtl/hex_disp_pkg.sv | 26 ++
 rtl/seg7_decode.sv | 31 +++
 rtl/hex_display_ctrl.sv | 157 +++++++++++++++
 tb/tb_hex_display_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_disp_pkg.sv
// Shared definitions for the HEX display controller.
//   mode_t       display mode held in CTRL[1:0]
//   ADDR_*       Avalon-MM register addresses
//   SEG_BLANK    active-low pattern with every segment off
//   CTRL_*       bit positions of the CTRL fields
package hex_disp_pkg;

  typedef enum logic [1:0] {
    STATIC = 2'd0,
    BLINK  = 2'd1,
    SCROLL = 2'd2,
    COUNT  = 2'd3
  } mode_t;

  localparam logic [1:0] ADDR_VALUE = 2'd0;
  localparam logic [1:0] ADDR_CTRL  = 2'd1;
  localparam logic [1:0] ADDR_RATE  = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int CTRL_MODE_LSB = 0;
  localparam int CTRL_MODE_W   = 2;
  localparam int CTRL_EN_LSB   = 8;
  localparam int CTRL_EN_W     = 8;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to seven-segment decoder.
//   nibble  4-bit value 0..F
//   seg     active-low segments, bit order gfedcba
module seg7_decode (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    unique case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit seven-segment controller with an Avalon-MM register set.
//   CLOCK_50       system clock
//   reset          synchronous, active-high
//   avs_*          register port: VALUE (0), CTRL (1), RATE (2), reserved (3)
//   hex_out        active-low segments, digit i in bits [7*i+6:7*i]
//   tick           one-cycle pulse at each prescaler expiry
//   count_wrap     one-cycle pulse when COUNT mode rolls over to 0
//
// Mode state:
//   mode    | meaning
//   STATIC  | digit i shows VALUE nibble i
//   BLINK   | phase toggles per tick, phase 1 blanks the display
//   SCROLL  | digit i shows nibble (i+offset) mod N_DIGITS, offset steps per tick
//   COUNT   | VALUE increments per tick
module hex_display_ctrl
  import hex_disp_pkg::*;
#(
  parameter int N_DIGITS     = 6,
  parameter int RATE_W       = 26,
  parameter int DEFAULT_RATE = 12_500_000
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [1:0]            avs_address,
  input  logic                  avs_write,
  input  logic [31:0]           avs_writedata,
  input  logic                  avs_read,
  output logic [31:0]           avs_readdata,
  output logic [7*N_DIGITS-1:0] hex_out,
  output logic                  tick,
  output logic                  count_wrap
);

  localparam int VAL_W = 4 * N_DIGITS;
  localparam int OFF_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [VAL_W-1:0]    value_q;
  mode_t               mode_q;
  logic [N_DIGITS-1:0] en_q;
  logic [RATE_W-1:0]   rate_q;
  logic [RATE_W-1:0]   cnt_q;
  logic [OFF_W-1:0]    offset_q;
  logic                phase_q;

  logic                wr_value, wr_ctrl, wr_rate;
  logic                expire;
  logic [RATE_W-1:0]   wd_rate;
  logic [31:0]         rd_data;
  logic [3:0]          disp_nib [N_DIGITS];
  logic [6:0]          dec_seg  [N_DIGITS];
  logic [7*N_DIGITS-1:0] hex_next;
  logic                unused_wdata;

  assign unused_wdata = ^avs_writedata;

  assign wr_value = avs_write && (avs_address == ADDR_VALUE);
  assign wr_ctrl  = avs_write && (avs_address == ADDR_CTRL);
  assign wr_rate  = avs_write && (avs_address == ADDR_RATE);
  assign wd_rate  = avs_writedata[RATE_W-1:0];
  assign expire   = (cnt_q == rate_q - RATE_W'(1));

  // Source nibble for a digit; SCROLL rotates, the sum never reaches 2*N.
  function automatic int nib_index(input int digit, input int off, input logic scroll);
    int idx;
    idx = digit;
    if (scroll) begin
      idx = digit + off;
      if (idx >= N_DIGITS) idx = idx - N_DIGITS;
    end
    return idx;
  endfunction

  always_comb begin
    for (int i = 0; i < N_DIGITS; i++) begin
      disp_nib[i] = value_q[4*nib_index(i, int'(offset_q), mode_q == SCROLL) +: 4];
    end
  end

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .nibble (disp_nib[g]),
      .seg    (dec_seg[g])
    );
  end

  always_comb begin
    hex_next = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (!en_q[i] || (mode_q == BLINK && phase_q)) hex_next[7*i +: 7] = SEG_BLANK;
      else                                          hex_next[7*i +: 7] = dec_seg[i];
    end
  end

  always_comb begin
    rd_data = '0;
    case (avs_address)
      ADDR_VALUE: rd_data[VAL_W-1:0] = value_q;
      ADDR_CTRL: begin
        rd_data[CTRL_MODE_LSB +: CTRL_MODE_W] = mode_q;
        rd_data[CTRL_EN_LSB +: N_DIGITS]      = en_q;
      end
      ADDR_RATE:  rd_data[RATE_W-1:0] = rate_q;
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      value_q      <= '0;
      mode_q       <= STATIC;
      en_q         <= '0;
      rate_q       <= RATE_W'(DEFAULT_RATE);
      cnt_q        <= '0;
      offset_q     <= '0;
      phase_q      <= 1'b0;
      avs_readdata <= '0;
      hex_out      <= '1;
      tick         <= 1'b0;
      count_wrap   <= 1'b0;
    end else begin
      tick       <= expire;
      count_wrap <= 1'b0;

      if (expire || wr_ctrl || wr_rate) cnt_q <= '0;
      else                              cnt_q <= cnt_q + RATE_W'(1);

      if (wr_rate) rate_q <= (wd_rate == '0) ? RATE_W'(1) : wd_rate;

      // A CTRL write restarts the mode from a clean state and suppresses
      // whatever mode action a coincident tick would have caused.
      if (wr_ctrl) begin
        mode_q   <= mode_t'(avs_writedata[CTRL_MODE_LSB +: CTRL_MODE_W]);
        en_q     <= avs_writedata[CTRL_EN_LSB +: N_DIGITS];
        offset_q <= '0;
        phase_q  <= 1'b0;
      end else if (expire) begin
        case (mode_q)
          BLINK:  phase_q <= ~phase_q;
          SCROLL: offset_q <= (offset_q == OFF_W'(N_DIGITS - 1)) ? '0 : offset_q + OFF_W'(1);
          default: ;
        endcase
      end

      // A host VALUE write takes priority over the COUNT increment.
      if (wr_value) begin
        value_q <= avs_writedata[VAL_W-1:0];
      end else if (expire && !wr_ctrl && mode_q == COUNT) begin
        value_q    <= value_q + VAL_W'(1);
        count_wrap <= &value_q;
      end

      if (avs_read) avs_readdata <= rd_data;
      hex_out <= hex_next;
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
module tb_hex_display_ctrl;

  localparam int RATE_DEF = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic [41:0] hex_out;
  logic        tick;
  logic        count_wrap;

  logic [1:0]  avs_address2;
  logic        avs_write2;
  logic [31:0] avs_writedata2;
  logic        avs_read2;
  logic [31:0] avs_readdata2;
  logic [13:0] hex_out2;
  logic        tick2;
  logic        count_wrap2;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [41:0] PAT_123456 = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
  localparam logic [41:0] ALL_BLANK  = {6{7'h7F}};

  always #5 clk = ~clk;

  hex_display_ctrl #(.N_DIGITS(6), .RATE_W(26), .DEFAULT_RATE(RATE_DEF)) dut (
    .CLOCK_50(clk), .reset(reset),
    .avs_address(avs_address), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_read(avs_read), .avs_readdata(avs_readdata),
    .hex_out(hex_out), .tick(tick), .count_wrap(count_wrap)
  );

  hex_display_ctrl #(.N_DIGITS(2), .RATE_W(26), .DEFAULT_RATE(RATE_DEF)) dut2 (
    .CLOCK_50(clk), .reset(reset),
    .avs_address(avs_address2), .avs_write(avs_write2), .avs_writedata(avs_writedata2),
    .avs_read(avs_read2), .avs_readdata(avs_readdata2),
    .hex_out(hex_out2), .tick(tick2), .count_wrap(count_wrap2)
  );

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    @(posedge clk); #1;
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic wr2(input logic [1:0] a, input logic [31:0] d);
    avs_address2 = a; avs_writedata2 = d; avs_write2 = 1'b1;
    @(posedge clk); #1;
    avs_write2 = 1'b0;
  endtask

  task automatic rd2(input logic [1:0] a, output logic [31:0] d);
    avs_address2 = a; avs_read2 = 1'b1;
    @(posedge clk); #1;
    avs_read2 = 1'b0;
    d = avs_readdata2;
  endtask

  // Expected display for VALUE=0x00000F in SCROLL at a given offset.
  function automatic logic [41:0] exp_scroll(input int off);
    logic [41:0] r;
    r = '0;
    for (int d = 0; d < 6; d++) r[7*d +: 7] = (((d + off) % 6) == 0) ? 7'h0E : 7'h40;
    return r;
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (hex_out !== ALL_BLANK) $display("FAIL reset_hex got=%h exp=%h", hex_out, ALL_BLANK);
    else n_pass++;
    n_total++;
    if ({avs_readdata, tick, count_wrap} !== 34'd0)
      $display("FAIL reset_outputs got rdata=%h tick=%b wrap=%b exp=0", avs_readdata, tick, count_wrap);
    else n_pass++;
    n_total++;
    if (hex_out2 !== 14'h3FFF) $display("FAIL reset_hex2 got=%h exp=3fff", hex_out2);
    else n_pass++;
    reset = 1'b0;
    rd(2'd2, d);
    n_total++;
    if (d !== 32'(RATE_DEF)) $display("FAIL reset_rate got=%0d exp=%0d", d, RATE_DEF);
    else n_pass++;
  endtask

  task automatic test_static();
    logic [31:0] d;
    wr(2'd0, 32'hAB12_3456);
    wr(2'd1, 32'h0000_3F00);
    @(posedge clk); #1;
    n_total++;
    if (hex_out !== PAT_123456) $display("FAIL static_hex got=%h exp=%h", hex_out, PAT_123456);
    else n_pass++;
    rd(2'd0, d);
    n_total++;
    if (d !== 32'h0012_3456) $display("FAIL static_readback got=%h exp=00123456", d);
    else n_pass++;
    rd(2'd1, d);
    n_total++;
    if (d !== 32'h0000_3F00) $display("FAIL ctrl_readback got=%h exp=00003f00", d);
    else n_pass++;
    wr(2'd1, 32'h0000_0500);
    @(posedge clk); #1;
    n_total++;
    if (hex_out !== {7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h7F, 7'h02})
      $display("FAIL partial_enable got=%h exp=%h", hex_out, {7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h7F, 7'h02});
    else n_pass++;
    rd(2'd3, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL reserved_read got=%h exp=0", d);
    else n_pass++;
  endtask

  task automatic test_blink();
    logic [41:0] exp_hex;
    wr(2'd2, 32'd4);
    wr(2'd1, 32'h0000_3F01);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      exp_hex = ((((k - 1) / 4) % 2) == 1) ? ALL_BLANK : PAT_123456;
      n_total++;
      if (tick !== ((k % 4) == 0)) $display("FAIL blink_tick k=%0d got=%b exp=%b", k, tick, (k % 4) == 0);
      else n_pass++;
      n_total++;
      if (hex_out !== exp_hex) $display("FAIL blink_hex k=%0d got=%h exp=%h", k, hex_out, exp_hex);
      else n_pass++;
    end
  endtask

  task automatic test_scroll();
    logic [41:0] e;
    wr(2'd2, 32'd2);
    wr(2'd0, 32'h0000_000F);
    wr(2'd1, 32'h0000_3F02);
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      e = exp_scroll(((k - 1) / 2) % 6);
      n_total++;
      if (hex_out !== e) $display("FAIL scroll_hex k=%0d got=%h exp=%h", k, hex_out, e);
      else n_pass++;
    end
  endtask

  task automatic test_count_wrap();
    logic [31:0] exp_rd [5];
    int wraps;
    exp_rd = '{32'hFE, 32'hFF, 32'h00, 32'h01, 32'h02};
    wraps = 0;
    wr2(2'd0, 32'h0000_00FE);
    wr2(2'd2, 32'd1);
    wr2(2'd1, 32'h0000_0303);
    avs_address2 = 2'd0; avs_read2 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      n_total++;
      if (avs_readdata2 !== exp_rd[k-1]) $display("FAIL count_value k=%0d got=%h exp=%h", k, avs_readdata2, exp_rd[k-1]);
      else n_pass++;
      if (count_wrap2) wraps++;
      if (k == 2) begin
        n_total++;
        if (count_wrap2 !== 1'b1) $display("FAIL count_wrap_cycle got=%b exp=1", count_wrap2);
        else n_pass++;
      end
      if (k == 4) begin
        n_total++;
        if (hex_out2 !== {7'h40, 7'h79}) $display("FAIL count_hex got=%h exp=%h", hex_out2, {7'h40, 7'h79});
        else n_pass++;
      end
    end
    avs_read2 = 1'b0;
    n_total++;
    if (wraps != 1) $display("FAIL count_wrap_once got=%0d exp=1", wraps);
    else n_pass++;
  endtask

  task automatic test_coincident();
    logic [31:0] d;
    wr2(2'd0, 32'h0000_0010);
    n_total++;
    if (count_wrap2 !== 1'b0) $display("FAIL write_no_wrap got=%b exp=0", count_wrap2);
    else n_pass++;
    rd2(2'd0, d);
    n_total++;
    if (d !== 32'h10) $display("FAIL write_wins got=%h exp=10", d);
    else n_pass++;
    rd2(2'd0, d);
    n_total++;
    if (d !== 32'h11) $display("FAIL next_increment got=%h exp=11", d);
    else n_pass++;
    wr(2'd2, 32'd0);
    rd(2'd2, d);
    n_total++;
    if (d !== 32'd1) $display("FAIL rate_zero got=%0d exp=1", d);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    avs_address = 2'd0; avs_writedata = 32'h0000_0055;
    avs_write = 1'b1; avs_read = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0; avs_read = 1'b0;
    n_total++;
    if (avs_readdata !== 32'h0F) $display("FAIL read_old_value got=%h exp=0f", avs_readdata);
    else n_pass++;
    rd(2'd0, d);
    n_total++;
    if (d !== 32'h55) $display("FAIL read_new_value got=%h exp=55", d);
    else n_pass++;
  endtask

  task automatic test_reset_mid_scroll();
    logic [31:0] d;
    int early;
    wr(2'd1, 32'h0000_3F02);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_total++;
    if (hex_out !== ALL_BLANK) $display("FAIL midreset_hex got=%h exp=%h", hex_out, ALL_BLANK);
    else n_pass++;
    n_total++;
    if ({avs_readdata, tick} !== 33'd0) $display("FAIL midreset_outputs got rdata=%h tick=%b exp=0", avs_readdata, tick);
    else n_pass++;
    early = 0;
    for (int k = 1; k <= RATE_DEF; k++) begin
      @(posedge clk); #1;
      if (k < RATE_DEF && tick) early++;
      if (k == RATE_DEF) begin
        n_total++;
        if (tick !== 1'b1) $display("FAIL first_tick_after_reset got=%b exp=1", tick);
        else n_pass++;
      end
    end
    n_total++;
    if (early != 0) $display("FAIL early_ticks got=%0d exp=0", early);
    else n_pass++;
    rd(2'd1, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL midreset_ctrl got=%h exp=0", d);
    else n_pass++;
    rd(2'd2, d);
    n_total++;
    if (d !== 32'(RATE_DEF)) $display("FAIL midreset_rate got=%0d exp=%0d", d, RATE_DEF);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    avs_address = '0; avs_write = 1'b0; avs_writedata = '0; avs_read = 1'b0;
    avs_address2 = '0; avs_write2 = 1'b0; avs_writedata2 = '0; avs_read2 = 1'b0;
    test_reset();
    test_static();
    test_blink();
    test_scroll();
    test_count_wrap();
    test_coincident();
    test_back_to_back();
    test_reset_mid_scroll();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
